// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor. On an accepted start the operands are
// captured. One bit is then resolved per clock, LSB first, through a
// single full-subtractor cell with a borrow flip-flop. The result appears
// WIDTH clocks after the start edge.
//
// Parameters
//   WIDTH       operand/result width, legal range 2..32
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request a new subtraction (only honoured when idle)
//   a, b        minuend / subtrahend, unsigned, captured on accepted start
//   busy        high while an operation is shifting or completing
//   done        one-cycle pulse, diff/borrow_out valid
//   diff        registered (a - b) mod 2^WIDTH, held until next completion
//   borrow_out  registered final borrow, 1 iff a < b
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter must be able to reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] d_sr_next;

  // One-bit full subtractor: returns {borrow_next, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic x, input logic y,
                                         input logic c);
    logic d;
    logic bo;
    d  = x ^ y ^ c;
    bo = (~x & y) | (~(x ^ y) & c);
    return {bo, d};
  endfunction

  always_comb begin
    {borrow_next, d_bit} = sub_bit(a_sr[0], b_sr[0], borrow);
    // New difference bit enters at the MSB; after WIDTH shifts bit 0 of
    // the result has walked down to the LSB.
    d_sr_next = {d_bit, {(WIDTH-1){1'b0}}} | (d_sr >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= d_sr_next;
          borrow <= borrow_next;
          cnt    <= cnt + CNT_W'(1);
          // Final bit: publish the result on this same edge.
          if (cnt == LAST_BIT) begin
            diff       <= d_sr_next;
            borrow_out <= borrow_next;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, unsigned; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, unsigned; captured on the accepted start edge.
REQ-007 SHALL have port busy  output  1  high while in SHIFT or DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH.
REQ-010 SHALL have port borrow_out  output  1  registered final borrow, 1 iff a < b unsigned.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL, on the same edge, load a and b into shift registers, clear the borrow flip-flop, clear the bit counter to 0 and go to SHIFT; IDLE with start=0 SHALL stay in IDLE.
REQ-013 Each SHIFT edge SHALL process one bit, LSB first, with x = a_sr[0], y = b_sr[0], c = borrow FF: d = x^y^c; next borrow = (~x&y) | (~(x^y)&c).
REQ-014 Each SHIFT edge SHALL shift a_sr and b_sr right by one, shift d into the MSB of an internal diff shift register, and increment the counter.
REQ-015 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1; on that same edge it SHALL copy the completed diff shift register to diff and the next-borrow value to borrow_out.
REQ-016 Latency: if start is accepted at edge k, SHALL hold done=1 for exactly the cycle after edge k+WIDTH and 0 otherwise.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge, so the throughput is one operation per WIDTH+2 cycles.
REQ-018 start SHALL be ignored in SHIFT and DONE.
REQ-019 Changes on a and b after the accepted start edge SHALL NOT affect the result in progress.
REQ-020 diff and borrow_out SHALL hold their last values until the next completion; they SHALL NOT change during SHIFT.
REQ-021 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-023 When rst=1 at an edge, the block SHALL go to IDLE and SHALL clear busy, done, diff, borrow_out, the counter, the borrow FF and all shift registers to 0.
REQ-024 rst SHALL have priority over start and over all state transitions.
REQ-025 rst asserted in SHIFT or DONE SHALL abort the operation; no done pulse SHALL follow, and diff and borrow_out SHALL read 0.
REQ-026 After rst deasserts, a start in the first cycle SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 Reset, then start with a=0x05, b=0x03 at edge k -> done=1 only in the cycle after edge k+8, diff=0x02, borrow_out=0; busy=1 from k+1 through k+9.
REQ-028 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; a=0x00, b=0xFF -> diff=0x01, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0x80, b=0x01 -> diff=0x7F, borrow_out=0.
REQ-029 Start a=0x10, b=0x01; during SHIFT, pulse start and change a and b to 0x00 and 0x55 -> result diff=0x0F, borrow_out=0, exactly one done pulse.
REQ-030 start held at 1 continuously with fixed operands -> done pulses every 10 cycles and busy drops to 0 for exactly one cycle between operations.
REQ-031 Complete a=0x09, b=0x04 (diff=0x05), then start a new operation and assert rst on its 4th SHIFT cycle -> no done, diff=0x00, borrow_out=0, busy=0; a following start with a=0x01, b=0x02 -> diff=0xFF, borrow_out=1.
REQ-032 With WIDTH=3, all 64 operand pairs -> diff = (a-b) mod 8 and borrow_out = (a<b), each checked against a scoreboard on done.
